axim_rd_arb: RTL and testbench
==============================

AXIM_RD_ARB -- requirements
Module: axim_rd_arb

Interface
REQ-001 SHALL have parameter N_SRC, default 4, giving the number of requesting AXI4 slave ports (2..16).
REQ-002 SHALL have parameter EN_CHK, default 1, which enables the burst-length checker.
REQ-003 SHALL have port aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port aresetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port s_axi[N_SRC], AXI4.s, array: requester ports; only the AR and R channels are used.
REQ-006 SHALL have port m_axi, AXI4.m: the shared downstream master; only the AR and R channels are used.
REQ-007 SHALL have port err_len, output, 1 bit: sticky flag meaning an rlast position did not match arlen.
REQ-008 SHALL have port err_src, output, $clog2(N_SRC) bits: the grant index captured at the first error.
REQ-009 SHALL tie off unused channels: s_axi awready/wready/bvalid = 0; m_axi awvalid/wvalid = 0, bready = 1.

Function
REQ-010 SHALL implement a state machine with three states, entered as follows:
- IDLE: after reset;
- ADDR: after an AR capture;
- DATA: after the m_axi AR handshake.
It returns to IDLE after the R beat with rlast completes.
REQ-011 In IDLE, SHALL pick the first s_axi[i].arvalid, searching from rr_ptr upward with wrap-around modulo N_SRC.
REQ-012 In IDLE with a winner g, SHALL assert s_axi[g].arready for exactly one cycle, latch all AR fields and g, and go to ADDR.
REQ-013 SHALL keep arready = 0 for every non-granted port and in every state other than IDLE.
REQ-014 In ADDR, SHALL drive m_axi.arvalid = 1 with the latched fields unchanged, and hold them until m_axi.arready = 1; then go to DATA.
REQ-015 SHALL give a latency of exactly 1 cycle from the s-side AR handshake to m_axi.arvalid rising.
REQ-016 In DATA, SHALL pass the R channel through combinationally for port g: s_axi[g].{rvalid,rdata,rresp,rlast,rid} = m_axi; m_axi.rready = s_axi[g].rready.
REQ-017 SHALL drive rvalid = 0 to all non-granted ports, and m_axi.rready = 0 outside DATA.
REQ-018 On an R handshake with rlast in DATA, SHALL set rr_ptr = (g+1) mod N_SRC and go to IDLE; a new grant is possible on the following cycle.
REQ-019 SHALL count R beats in DATA with a 9-bit beat counter, cleared on entry to DATA.
REQ-020 When EN_CHK = 1, SHALL set err_len = 1 and latch err_src = g if rlast arrives with count != arlen, or count reaches arlen without rlast; the FSM still leaves DATA only on rlast.
REQ-021 SHALL clear err_len only on reset.
REQ-022 SHALL not change rr_ptr when no arvalid is present in IDLE.
REQ-023 SHALL handle simultaneous arvalid on all ports by the round-robin rule only, with no priority starvation: each port waits at most N_SRC-1 bursts.
REQ-024 SHALL allow at most one outstanding read burst at any time.

Reset
REQ-025 On aresetn = 0, SHALL immediately set: state = IDLE, rr_ptr = 0, all arready/rvalid/m_axi.arvalid/m_axi.rready = 0, err_len = 0, err_src = 0, beat counter = 0.
REQ-026 SHALL not replay an in-flight burst after reset; downstream is reset together with this block.
REQ-027 SHALL release from reset synchronously to aclk; no valid is asserted in the first cycle after deassertion.

Structure
REQ-028 SHALL place the state enum (ARB_IDLE, ARB_ADDR, ARB_DATA) in lynxTypes.
REQ-029 SHALL keep N_SRC_BITS = $clog2(N_SRC) as a module localparam.
REQ-030 SHALL put round-robin selection in one combinational sub-module, rr_pick, with inputs req[N_SRC] and ptr, and outputs vld and idx.

Verification
REQ-031 Single burst: s_axi[2] AR addr 0x1000, arlen 3; downstream returns 4 beats -> m arvalid one cycle after capture; s_axi[2] receives 4 beats with rlast on beat 4; rr_ptr = 3; err_len = 0.
REQ-032 Contention: all 4 ports request continuously, arlen 0, after reset -> grant order 0,1,2,3,0; other ports never see rvalid.
REQ-033 Backpressure: m_axi.arready held 0 for 5 cycles, then s_axi[1].rready toggling -> m_axi AR fields stable for 5 cycles; no beat lost or duplicated; m_axi.rready follows s_axi[1].rready.
REQ-034 Length error: arlen 7, downstream asserts rlast on beat 4 on port 3 -> err_len = 1 and err_src = 3; FSM returns to IDLE; the next grant is port 0.
REQ-035 Reset mid-burst: aresetn low during DATA beat 2 -> all valids low within the same cycle; after release, state is IDLE, rr_ptr = 0, err_len = 0.
REQ-036 Wrap: rr_ptr = 3 and requests only on ports 1 and 2 -> port 1 is granted first.

Source files
------------

// File: rtl/lynxTypes.sv
// Shared types for the AXI4 read arbiter slice.
// Holds the arbiter state encoding and the latched AR bundle.
package lynxTypes;

  localparam int AXI_AW = 32;
  localparam int AXI_DW = 32;
  localparam int AXI_IW = 4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ADDR,
    ARB_DATA
  } arb_state_t;

  typedef struct packed {
    logic [AXI_AW-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic [AXI_IW-1:0] id;
  } ar_t;

endpackage

// File: rtl/AXI4.sv
// Reduced AXI4 bundle: full AR/R channels, AW/W/B as handshakes only.
// The arbiter never writes, so the write path carries no payload.
interface AXI4;
  import lynxTypes::*;

  logic [AXI_AW-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [AXI_IW-1:0] arid;
  logic              arvalid;
  logic              arready;

  logic [AXI_DW-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic [AXI_IW-1:0] rid;
  logic              rvalid;
  logic              rready;

  logic awvalid, awready;
  logic wvalid, wready;
  logic bvalid, bready;

  modport m (
    output araddr, arlen, arsize, arburst, arid, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rid, rvalid,
    output rready,
    output awvalid, wvalid, bready,
    input  awready, wready, bvalid
  );

  modport s (
    input  araddr, arlen, arsize, arburst, arid, arvalid,
    output arready,
    output rdata, rresp, rlast, rid, rvalid,
    input  rready,
    input  awvalid, wvalid, bready,
    output awready, wready, bvalid
  );

endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping.
// Purely combinational; vld is low when no request is set.
module rr_pick #(
  parameter int N_SRC = 4,
  parameter int W     = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [W-1:0]     ptr,
  output logic             vld,
  output logic [W-1:0]     idx
);

  logic [N_SRC-1:0] rot;
  logic [W:0]       sum;

  always_comb begin
    vld = 1'b0;
    idx = '0;
    sum = '0;
    rot = N_SRC'({req, req} >> ptr);
    // Descending scan so the lowest offset from ptr wins.
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (rot[k]) begin
        vld = 1'b1;
        sum = {1'b0, ptr} + (W+1)'(k);
        if (sum >= (W+1)'(N_SRC))
          sum = sum - (W+1)'(N_SRC);
        idx = sum[W-1:0];
      end
    end
  end

endmodule

// File: rtl/axim_rd_arb.sv
// N-to-1 AXI4 read arbiter, one burst in flight, round-robin grant.
// Optional checker flags rlast landing off the arlen position.
module axim_rd_arb
  import lynxTypes::*;
#(
  parameter int N_SRC  = 4,
  parameter int EN_CHK = 1
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  AXI4.s                           s_axi [N_SRC],
  AXI4.m                           m_axi,
  output logic                     err_len,
  output logic [$clog2(N_SRC)-1:0] err_src
);

  localparam int N_SRC_BITS = $clog2(N_SRC);
  typedef logic [N_SRC_BITS-1:0] idx_t;

  arb_state_t state_q, state_d;
  ar_t        ar_q, ar_d;
  idx_t       gnt_q, gnt_d;
  idx_t       ptr_q, ptr_d;
  idx_t       esrc_q, esrc_d;
  logic [8:0] beat_q, beat_d;
  logic       err_q, err_d;
  logic       run_q;

  idx_t             pick_idx;
  logic             pick_vld;
  logic             r_hs;
  logic [N_SRC-1:0] arvalid;
  logic [N_SRC-1:0] arready;
  logic [N_SRC-1:0] rready;
  ar_t              ar_in [N_SRC];
  logic [N_SRC-1:0] unused_s;
  logic             unused_m;

  rr_pick #(
    .N_SRC (N_SRC),
    .W     (N_SRC_BITS)
  ) u_pick (
    .req (arvalid),
    .ptr (ptr_q),
    .vld (pick_vld),
    .idx (pick_idx)
  );

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    assign arvalid[i] = s_axi[i].arvalid;
    assign rready[i]  = s_axi[i].rready;
    assign ar_in[i]   = '{
      addr:  s_axi[i].araddr,
      len:   s_axi[i].arlen,
      size:  s_axi[i].arsize,
      burst: s_axi[i].arburst,
      id:    s_axi[i].arid
    };
    assign s_axi[i].arready = arready[i];
    assign s_axi[i].rvalid  = (state_q == ARB_DATA) &&
                              (gnt_q == idx_t'(i)) &&
                              m_axi.rvalid;
    assign s_axi[i].rdata   = m_axi.rdata;
    assign s_axi[i].rresp   = m_axi.rresp;
    assign s_axi[i].rlast   = m_axi.rlast;
    assign s_axi[i].rid     = m_axi.rid;
    assign s_axi[i].awready = 1'b0;
    assign s_axi[i].wready  = 1'b0;
    assign s_axi[i].bvalid  = 1'b0;
    assign unused_s[i] = s_axi[i].awvalid ^
                         s_axi[i].wvalid ^
                         s_axi[i].bready;
  end

  assign m_axi.arvalid = (state_q == ARB_ADDR);
  assign m_axi.araddr  = ar_q.addr;
  assign m_axi.arlen   = ar_q.len;
  assign m_axi.arsize  = ar_q.size;
  assign m_axi.arburst = ar_q.burst;
  assign m_axi.arid    = ar_q.id;
  assign m_axi.rready  = (state_q == ARB_DATA) && rready[gnt_q];
  assign m_axi.awvalid = 1'b0;
  assign m_axi.wvalid  = 1'b0;
  assign m_axi.bready  = 1'b1;
  assign unused_m = m_axi.awready ^ m_axi.wready ^ m_axi.bvalid;

  assign r_hs    = m_axi.rvalid && m_axi.rready;
  assign err_len = err_q;
  assign err_src = esrc_q;

  // run_q keeps arready low for the first cycle out of reset.
  always_comb begin
    arready = '0;
    if (run_q && state_q == ARB_IDLE && pick_vld)
      arready[pick_idx] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ar_d    = ar_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    err_d   = err_q;
    esrc_d  = esrc_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (run_q && pick_vld) begin
          ar_d    = ar_in[pick_idx];
          gnt_d   = pick_idx;
          state_d = ARB_ADDR;
        end
      end
      ARB_ADDR: begin
        if (m_axi.arready) begin
          beat_d  = '0;
          state_d = ARB_DATA;
        end
      end
      ARB_DATA: begin
        if (r_hs) begin
          beat_d = beat_q + 9'd1;
          // rlast must coincide exactly with beat index arlen.
          if (EN_CHK != 0 &&
              (m_axi.rlast != (beat_q == {1'b0, ar_q.len}))) begin
            err_d = 1'b1;
            if (!err_q)
              esrc_d = gnt_q;
          end
          if (m_axi.rlast) begin
            ptr_d   = (gnt_q == idx_t'(N_SRC - 1)) ?
                      '0 : gnt_q + 1'b1;
            state_d = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ARB_IDLE;
      ar_q    <= '0;
      gnt_q   <= '0;
      ptr_q   <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      esrc_q  <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ar_q    <= ar_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      esrc_q  <= esrc_d;
      run_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axim_rd_arb.sv
// Directed bench for axim_rd_arb with N_SRC = 4.
// Bench plays both the requesters and the downstream slave.
module tb_axim_rd_arb;
  import lynxTypes::*;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  int n_chk = 0;
  int n_err = 0;

  logic [3:0]  s_arvalid, s_rready;
  logic [3:0]  s_arready, s_rvalid, s_rlast;
  logic [31:0] s_araddr [4];
  logic [7:0]  s_arlen  [4];
  logic [31:0] s_rdata  [4];

  logic        m_arready, m_rvalid, m_rlast;
  logic [31:0] m_rdata;
  logic [3:0]  m_rid;
  logic        m_arvalid, m_rready;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;

  logic       err_len;
  logic [1:0] err_src;

  AXI4 s_if [4] ();
  AXI4 m_if ();

  for (genvar i = 0; i < 4; i++) begin : g_s
    assign s_if[i].arvalid = s_arvalid[i];
    assign s_if[i].araddr  = s_araddr[i];
    assign s_if[i].arlen   = s_arlen[i];
    assign s_if[i].arsize  = 3'd2;
    assign s_if[i].arburst = 2'b01;
    assign s_if[i].arid    = 4'(i);
    assign s_if[i].rready  = s_rready[i];
    assign s_if[i].awvalid = 1'b0;
    assign s_if[i].wvalid  = 1'b0;
    assign s_if[i].bready  = 1'b0;
    assign s_arready[i] = s_if[i].arready;
    assign s_rvalid[i]  = s_if[i].rvalid;
    assign s_rlast[i]   = s_if[i].rlast;
    assign s_rdata[i]   = s_if[i].rdata;
  end

  assign m_if.arready = m_arready;
  assign m_if.rvalid  = m_rvalid;
  assign m_if.rdata   = m_rdata;
  assign m_if.rresp   = 2'b00;
  assign m_if.rlast   = m_rlast;
  assign m_if.rid     = m_rid;
  assign m_if.awready = 1'b0;
  assign m_if.wready  = 1'b0;
  assign m_if.bvalid  = 1'b0;
  assign m_arvalid = m_if.arvalid;
  assign m_rready  = m_if.rready;
  assign m_araddr  = m_if.araddr;
  assign m_arlen   = m_if.arlen;

  axim_rd_arb #(
    .N_SRC  (4),
    .EN_CHK (1)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_axi   (s_if),
    .m_axi   (m_if),
    .err_len (err_len),
    .err_src (err_src)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    @(negedge aclk);
  endtask

  // One arlen-0 burst for whichever port in mask wins.
  task automatic serve_one(input logic [3:0] mask,
                           input int exp_win);
    int win;
    int n;
    win = -1;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      s_araddr[k] = 32'h100 * k;
      s_arlen[k]  = 8'd0;
    end
    s_arvalid = mask;
    s_rready  = 4'hF;
    #1;
    while (s_arready == 4'd0 && n < 20) begin
      step();
      #1;
      n++;
    end
    for (int k = 0; k < 4; k++)
      if (s_arready[k]) win = k;
    chk("grant", 64'(win), 64'(exp_win));
    chk("gnt_onehot", 64'($countones(s_arready)), 64'd1);
    if (win < 0) return;
    step();
    m_arready = 1'b1;
    #1;
    chk("m_addr", 64'(m_araddr), 64'(32'h100 * win));
    step();
    m_arready = 1'b0;
    m_rvalid  = 1'b1;
    m_rlast   = 1'b1;
    m_rdata   = 32'hC0DE_0000 + 32'(win);
    #1;
    chk("rv_only_gnt", 64'(s_rvalid), 64'(1) << win);
    step();
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
  endtask

  task automatic run_burst(input int p,
                           input logic [31:0] addr,
                           input logic [7:0] len,
                           input int last_at,
                           input int stall,
                           input bit tog,
                           input int rst_at);
    int n;
    int b;
    int c;
    int got;
    s_araddr[p]  = addr;
    s_arlen[p]   = len;
    s_arvalid[p] = 1'b1;
    s_rready     = 4'hF;
    n = 0;
    #1;
    while (!s_arready[p] && n < 20) begin
      step();
      #1;
      n++;
    end
    chk("ar_grant", 64'(s_arready[p]), 64'd1);
    step();
    chk("ar_lat", 64'(m_arvalid), 64'd1);
    chk("arready_1cyc", 64'(s_arready[p]), 64'd0);
    chk("ar_fields", 64'({m_araddr, m_arlen}), 64'({addr, len}));
    s_arvalid[p] = 1'b0;
    for (int k = 0; k < stall; k++) begin
      #1;
      chk("ar_hold", 64'({m_arvalid, m_araddr, m_arlen}),
          64'({1'b1, addr, len}));
      step();
    end
    m_arready = 1'b1;
    step();
    m_arready = 1'b0;
    b = 0;
    c = 0;
    got = 0;
    while (b <= last_at && c < 64) begin
      s_rready[p] = tog ? c[0] : 1'b1;
      m_rvalid = 1'b1;
      m_rlast  = (b == last_at);
      m_rdata  = 32'hD000_0000 + 32'(p << 8) + 32'(b);
      m_rid    = 4'(p);
      if (b == rst_at) begin
        aresetn = 1'b0;
        #1;
        chk("rst_vld",
            64'({s_rvalid, s_arready, m_arvalid, m_rready}), 64'd0);
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        step();
        aresetn   = 1'b1;
        s_arvalid = 4'b0001;
        #1;
        chk("rst_first", 64'(s_arready), 64'd0);
        chk("rst_err", 64'({err_len, err_src}), 64'd0);
        s_arvalid = 4'd0;
        step();
        return;
      end
      #1;
      chk("r_vld", 64'(s_rvalid), 64'(1) << p);
      chk("r_data", 64'(s_rdata[p]),
          64'(32'hD000_0000 + 32'(p << 8) + 32'(b)));
      chk("r_last", 64'(s_rlast[p]), 64'(b == last_at));
      chk("r_ready", 64'(m_rready), 64'(s_rready[p]));
      if (m_rready) begin
        got++;
        b++;
      end
      step();
      c++;
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    s_rready = 4'hF;
    chk("r_beats", 64'(got), 64'(last_at + 1));
  endtask

  initial begin
    s_arvalid = 4'b0001;
    s_rready  = 4'hF;
    for (int k = 0; k < 4; k++) begin
      s_araddr[k] = '0;
      s_arlen[k]  = '0;
    end
    m_arready = 1'b0;
    m_rvalid  = 1'b1;
    m_rlast   = 1'b0;
    m_rdata   = '0;
    m_rid     = '0;

    @(negedge aclk);
    #1;
    chk("rst_arready", 64'(s_arready), 64'd0);
    chk("rst_mvalid", 64'({m_arvalid, m_rready}), 64'd0);
    chk("rst_rvalid", 64'(s_rvalid), 64'd0);
    chk("rst_errs", 64'({err_len, err_src}), 64'd0);
    chk("tie_offs",
        64'({m_if.awvalid, m_if.wvalid, m_if.bready,
             s_if[0].awready, s_if[0].wready, s_if[0].bvalid}),
        64'(6'b001000));
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    chk("first_cycle", 64'(s_arready), 64'd0);
    s_arvalid = 4'd0;
    m_rvalid  = 1'b0;
    step();

    serve_one(4'hF, 0);
    serve_one(4'hF, 1);
    serve_one(4'hF, 2);
    serve_one(4'hF, 3);
    serve_one(4'hF, 0);
    s_arvalid = 4'd0;

    run_burst(2, 32'h1000, 8'd3, 3, 0, 1'b0, -1);
    chk("no_err_single", 64'(err_len), 64'd0);
    serve_one(4'b1001, 3);
    s_arvalid = 4'd0;

    run_burst(2, 32'h2000, 8'd0, 0, 0, 1'b0, -1);
    serve_one(4'b0110, 1);
    s_arvalid = 4'd0;

    run_burst(1, 32'h3000, 8'd5, 5, 5, 1'b1, -1);
    chk("no_err_bp", 64'(err_len), 64'd0);

    run_burst(3, 32'h4000, 8'd7, 3, 0, 1'b0, -1);
    chk("len_err", 64'({err_len, err_src}), 64'({1'b1, 2'd3}));
    serve_one(4'hF, 0);
    s_arvalid = 4'd0;

    run_burst(1, 32'h4100, 8'd1, 3, 0, 1'b0, -1);
    chk("err_sticky", 64'({err_len, err_src}), 64'({1'b1, 2'd3}));

    run_burst(0, 32'h5000, 8'd3, 3, 0, 1'b0, 2);
    serve_one(4'b1001, 0);
    s_arvalid = 4'd0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
